// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Takes the ALU result as the effective address and rs2 as store data.
// Issues word-aligned requests with byte enables over a req/gnt/rvalid
// handshake, and returns sign- or zero-extended load data.
// Holds the upstream pipeline while an access is outstanding.
module mem_access_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DWIDTH-1:0] load_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         NLANES   = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_reg;
    logic              is_store_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        offset_reg;
    logic              done_reg;
    logic              err_reg;
    logic [DWIDTH-1:0] load_data_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [AWIDTH-1:0] mem_addr_reg;
    logic [3:0]        mem_be_reg;
    logic [DWIDTH-1:0] mem_wdata_reg;

    logic              is_load;
    logic              is_store;
    logic              mem_op;
    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_next;
    logic [DWIDTH-1:0] wdata_next;
    logic [DWIDTH-1:0] rdata_shifted;
    logic [DWIDTH-1:0] load_data_next;

    assign is_load  = (opcode_i == OP_LOAD);
    assign is_store = (opcode_i == OP_STORE);
    assign mem_op   = valid_i && (is_load || is_store);

    // Sizes 011/110/111 do not exist; unsigned variants only exist for loads.
    assign illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                     (funct3_i == 3'b111) || (is_store && funct3_i[2]);

    // Halfwords need even addresses, words need 4-byte alignment.
    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    // Byte enables for the addressed lanes of the word.
    always_comb begin
        be_next = 4'b1111;
        case (funct3_i[1:0])
            2'b00:   be_next = 4'b0001 << addr_i[1:0];
            2'b01:   be_next = 4'b0011 << addr_i[1:0];
            default: be_next = 4'b1111;
        endcase
    end

    // Store data replicated across byte lanes so any enabled lane sees it.
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_wlane
            always_comb begin
                wdata_next[8*gi +: 8] = store_data_i[8*gi +: 8];
                case (funct3_i[1:0])
                    2'b00:   wdata_next[8*gi +: 8] = store_data_i[7:0];
                    2'b01:   wdata_next[8*gi +: 8] = store_data_i[8*(gi%2) +: 8];
                    default: wdata_next[8*gi +: 8] = store_data_i[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    assign rdata_shifted = mem_rdata_i >> {offset_reg, 3'b000};

    // Extract the addressed byte/halfword from the returned word and extend it.
    always_comb begin
        load_data_next = mem_rdata_i;
        case (funct3_reg)
            3'b000:  load_data_next = {{(DWIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_data_next = {{(DWIDTH-8){1'b0}}, rdata_shifted[7:0]};
            3'b001:  load_data_next = {{(DWIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_data_next = {{(DWIDTH-16){1'b0}}, rdata_shifted[15:0]};
            default: load_data_next = mem_rdata_i;
        endcase
    end

    // Access sequencer: accept, request until granted, wait for data, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            is_store_reg  <= 1'b0;
            funct3_reg    <= 3'b000;
            offset_reg    <= 2'b00;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            load_data_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        is_store_reg <= is_store;
                        funct3_reg   <= funct3_i;
                        offset_reg   <= addr_i[1:0];
                        if (illegal || misaligned) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg     <= REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= is_store;
                            mem_addr_reg  <= {addr_i[AWIDTH-1:2], 2'b00};
                            mem_be_reg    <= be_next;
                            mem_wdata_reg <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        if (is_store_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        load_data_reg <= load_data_next;
                        state_reg     <= DONE;
                        done_reg      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign stall_o     = ((state_reg == IDLE) && mem_op) ||
                         (state_reg == REQ) || (state_reg == WAIT);
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign load_data_o = load_data_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_be_o    = mem_be_reg;
    assign mem_wdata_o = mem_wdata_reg;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the pd5 pipeline. It consumes the execute-stage ALU result as the effective address and the rs2 value as store data. It issues word-aligned requests with byte enables to the data memory over a req/gnt/rvalid handshake, and returns sign- or zero-extended load data. It stalls the upstream pipeline while a memory access is outstanding.

## Interface
- DWIDTH, 32, data width
- AWIDTH, 32, address width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- valid_i  in  1  instruction in memory stage is valid
- opcode_i  in  7  LOAD 7'b0000011 or STORE 7'b0100011; any other opcode is ignored
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  AWIDTH  effective address (ALU result)
- store_data_i  in  DWIDTH  rs2 value
- stall_o  out  1  hold the pipeline upstream of this unit
- done_o  out  1  one-cycle pulse; access complete
- err_o  out  1  one-cycle pulse with done_o; misaligned address or illegal funct3
- load_data_o  out  DWIDTH  extended load result; valid when done_o=1 for a load
- mem_req_o  out  1  request to data memory
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o  out  AWIDTH  {addr[AWIDTH-1:2], 2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DWIDTH  lane-replicated store data
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DWIDTH  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no access:
  - valid_i=0, or the opcode is not LOAD/STORE: unit inert.
  - stall_o=0.
- IDLE, memory op with valid_i=1 (accept cycle):
  - stall_o=1, combinational.
  - Latch opcode, funct3, addr and store_data.
  - Illegal funct3 (011, 110, 111, or 100/101 on a STORE): go to DONE with error flag set. No memory request is issued.
  - Misaligned (H/HU with addr[0]=1, or W with addr[1:0]!=0): go to DONE with error flag set. No memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1.
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i=1.
  - On gnt, a store goes to DONE and a load goes to WAIT.
  - mem_rvalid_i is ignored in this state.
- WAIT:
  - On mem_rvalid_i, register the extracted and extended data into load_data_o, then go to DONE.
- DONE:
  - done_o=1, and err_o=error flag.
  - stall_o=0.
  - Next state IDLE.
  - A new access cannot be accepted in DONE; it is accepted in the following IDLE cycle.
- stall_o=1 in REQ and WAIT.
- Byte enables (k = addr[1:0]):
  - B/BU: 4'b0001<<k
  - H/HU: 4'b0011<<k
  - W: 4'b1111
- Store data:
  - SB: {4{data[7:0]}}
  - SH: {2{data[15:0]}}
  - SW: data
- Load extract:
  - sh = mem_rdata_i >> (8*k).
  - B: sign-extend sh[7:0]; BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]; HU: zero-extend sh[15:0].
  - W: mem_rdata_i.
- load_data_o holds its last value until the next completed load. Stores and errors do not change it.
- mem_rvalid_i is ignored in IDLE, REQ and DONE.

## Timing
- Reset: state IDLE. All outputs are 0, including load_data_o and the mem_* outputs.
- Access accepted at cycle T, with gnt in the first REQ cycle and rvalid one cycle later:
  - Load: REQ at T+1, WAIT at T+2, done_o at T+3.
  - Store: REQ at T+1, done_o at T+2.
  - Error: done_o and err_o at T+1.
- Each cycle gnt is delayed adds one REQ cycle. Each cycle rvalid is delayed adds one WAIT cycle.
- done_o rises exactly one cycle after the gnt cycle (store) or the rvalid cycle (load).
- Memory contract: rvalid arrives at least one cycle after gnt, and at most one request is outstanding.
- Reset in any state:
  - Next cycle is IDLE, with mem_req_o=0 and stall_o=0.
  - A late rvalid for an aborted load is ignored.
  - No done_o pulse is produced.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, gnt immediate -> at T+1 mem_req_o=1, mem_we_o=1, mem_addr_o=0x100, mem_be_o=4'b1111, mem_wdata_o=0xDEADBEEF; done_o at T+2; stall_o=1 at T and T+1.
- SB, addr 0x103, data 0x000000A5 -> mem_addr_o=0x100, mem_be_o=4'b1000, mem_wdata_o=0xA5A5A5A5.
- LB, addr 0x202, rdata 0x12F03456 -> load_data_o=0xFFFFFFF0 at done. Repeat as LBU -> 0x000000F0. LHU at addr 0x202 -> 0x000012F0.
- LH, addr 0x201 -> no mem_req_o; done_o=1 and err_o=1 at T+1; load_data_o unchanged. Repeat with funct3=011 on a load -> same response.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> request signals stable throughout REQ; stall_o high from T until done; done_o exactly one cycle after rvalid; rvalid pulsed during REQ is ignored.
- Reset asserted in WAIT, then rvalid pulsed -> IDLE next cycle with all outputs 0, no done_o, load_data_o=0.
